// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed seven-segment scan driver.
//   - nibble_t / seg_t : widths of a hex digit and of a segment bus
//   - SEG_OFF          : all segments dark (active-high form)
//   - SEG_HEX_0..F     : active-high segment patterns {g,f,e,d,c,b,a}, bit0 = a
// Polarity inversion is not applied here; the driver applies it at its
// output registers so every pattern in this file stays active-high.
// -----------------------------------------------------------------------------
package seg_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;

  localparam seg_t SEG_HEX_0 = 7'b0111111;
  localparam seg_t SEG_HEX_1 = 7'b0000110;
  localparam seg_t SEG_HEX_2 = 7'b1011011;
  localparam seg_t SEG_HEX_3 = 7'b1001111;
  localparam seg_t SEG_HEX_4 = 7'b1100110;
  localparam seg_t SEG_HEX_5 = 7'b1101101;
  localparam seg_t SEG_HEX_6 = 7'b1111101;
  localparam seg_t SEG_HEX_7 = 7'b0000111;
  localparam seg_t SEG_HEX_8 = 7'b1111111;
  localparam seg_t SEG_HEX_9 = 7'b1101111;
  localparam seg_t SEG_HEX_A = 7'b1110111;
  localparam seg_t SEG_HEX_B = 7'b1111100;
  localparam seg_t SEG_HEX_C = 7'b0111001;
  localparam seg_t SEG_HEX_D = 7'b1011110;
  localparam seg_t SEG_HEX_E = 7'b1111001;
  localparam seg_t SEG_HEX_F = 7'b1110001;

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex-to-seven-segment decoder (active-high segments).
// Ports:
//   nibble : in  4  hex value 0..F
//   seg    : out 7  segment pattern {g,f,e,d,c,b,a}, bit0 = a
// -----------------------------------------------------------------------------
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // One pattern per hex value; lower-case b and d keep them distinct from 8 and 0.
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for NUM_DIGITS seven-segment digits. A prescaler
// sets the dwell time per digit; new values are written into a shadow
// register and only become visible at the start of a frame (digit 0), so a
// frame never shows a mix of old and new digits.
//
// Parameters:
//   NUM_DIGITS : number of digits (1..8)
//   SCAN_DIV   : clock cycles per digit slot (>= 2)
//   ACTIVE_LOW : 1 inverts seg_o, dp_o and an_o
//
// Ports:
//   clk      : in  1             system clock, rising edge
//   rst_n    : in  1             asynchronous active-low reset
//   digits_i : in  4*NUM_DIGITS  hex nibbles, nibble k = digit k (0 rightmost)
//   dp_i     : in  NUM_DIGITS    decimal point per digit
//   load_i   : in  1             capture digits_i/dp_i into the shadow register
//   blank_i  : in  1             force all digits dark
//   seg_o    : out 7             segments {g,f,e,d,c,b,a}, bit0 = a
//   dp_o     : out 1             decimal point of the active digit
//   an_o     : out NUM_DIGITS    one-hot digit enable
//   frame_o  : out 1             one-cycle pulse after the frame wraps
//
// Build option:
//   SEG_SCAN_LZB_EN : when defined, leading zeros (digit k > 0 whose nibble
//                     and all higher nibbles are 0) show no segments while
//                     their anode and decimal point still operate.
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic                      load_i,
  input  logic                      blank_i,
  output logic [6:0]                seg_o,
  output logic                      dp_o,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic                      frame_o
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W  = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

  // XOR masks applied when the outputs are registered; with ACTIVE_LOW the
  // "off" levels become all ones.
  localparam logic                  INV    = (ACTIVE_LOW != 0);
  localparam seg_t                  SEG_INV = {7{INV}};
  localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{INV}};

  logic [PRE_W-1:0]      prescaler;
  logic [IDX_W-1:0]      index;
  logic                  tick;
  logic                  wrap_tick;

  logic [DATA_W-1:0]     shadow;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic                  pending;
  logic [DATA_W-1:0]     active;
  logic [NUM_DIGITS-1:0] active_dp;

  nibble_t               cur_nibble;
  logic                  cur_dp;
  logic                  cur_dark;
  seg_t                  dec_seg;

  seg_t                  seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign tick      = (prescaler == LAST_PRE);
  assign wrap_tick = tick && (index == LAST_IDX);

  // Prescaler: counts out one digit slot, then restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit index: steps once per slot and wraps after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index <= '0;
    end else if (tick) begin
      if (index == LAST_IDX) begin
        index <= '0;
      end else begin
        index <= index + 1'b1;
      end
    end
  end

  // Shadow register and pending flag. A load on the wrap edge takes
  // priority, so pending stays set and the new value waits a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
    end else begin
      if (load_i) begin
        shadow    <= digits_i;
        shadow_dp <= dp_i;
        pending   <= 1'b1;
      end else if (wrap_tick) begin
        pending   <= 1'b0;
      end
    end
  end

  // Active register only changes at the frame boundary, using the shadow
  // contents from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      active_dp <= '0;
    end else if (wrap_tick && pending) begin
      active    <= shadow;
      active_dp <= shadow_dp;
    end
  end

  // Frame marker, high for the cycle after the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_o <= 1'b0;
    end else begin
      frame_o <= wrap_tick;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[k] is set when nibbles k..NUM_DIGITS-1 of the active value are
  // all zero, built downward from the most significant digit.
  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = (active[DATA_W-1 -: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      zero_from[k] = zero_from[k+1] && (active[4*k +: 4] == 4'h0);
    end
  end
`endif

  // Select the nibble and decimal point of the digit currently scanned, and
  // decide whether its segments are suppressed as a leading zero.
  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_dark   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index == IDX_W'(k)) begin
        cur_nibble = active[4*k +: 4];
        cur_dp     = active_dp[k];
`ifdef SEG_SCAN_LZB_EN
        cur_dark   = (k != 0) && zero_from[k];
`endif
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Active-high view of the next output values; blanking overrides
  // everything while the scan itself keeps running.
  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = 1'b0;
    an_next  = '0;
    if (!blank_i) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_next[k] = (index == IDX_W'(k));
      end
      seg_next = cur_dark ? SEG_OFF : dec_seg;
      dp_next  = cur_dp;
    end
  end

  // Output registers with polarity applied as the very last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o <= SEG_OFF ^ SEG_INV;
      dp_o  <= INV;
      an_o  <= AN_INV;
    end else begin
      seg_o <= seg_next ^ SEG_INV;
      dp_o  <= dp_next ^ INV;
      an_o  <= an_next ^ AN_INV;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (>=2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts seg_o, dp_o, an_o.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port digits_i  input  4*NUM_DIGITS  hex nibbles; nibble k = digit k, k=0 rightmost.
REQ-007 SHALL have port dp_i  input  NUM_DIGITS  decimal point per digit.
REQ-008 SHALL have port load_i  input  1  capture digits_i/dp_i into shadow register.
REQ-009 SHALL have port blank_i  input  1  force all digits dark.
REQ-010 SHALL have port seg_o  output  7  segments {g,f,e,d,c,b,a}, bit0=a.
REQ-011 SHALL have port dp_o  output  1  decimal point of active digit.
REQ-012 SHALL have port an_o  output  NUM_DIGITS  one-hot digit enable.
REQ-013 SHALL have port frame_o  output  1  one-cycle pulse at frame wrap.
REQ-014 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-015 SHALL decode nibble: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001 (active-high form).
REQ-016 SHALL count prescaler 0..SCAN_DIV-1; tick when prescaler==SCAN_DIV-1, then prescaler wraps to 0.
REQ-017 SHALL advance digit index on tick; index NUM_DIGITS-1 wraps to 0.
REQ-018 SHALL, on load_i high at a clock edge, capture digits_i/dp_i into shadow and set pending; later load_i overwrites shadow.
REQ-019 SHALL copy shadow to active register and clear pending only on the tick that wraps index to 0; load_i on that same edge wins (shadow updated, pending stays set, copy takes old shadow).
REQ-020 SHALL pulse frame_o for exactly the cycle after the wrap tick.
REQ-021 SHALL register seg_o, dp_o, an_o: they reflect the index and active register one cycle after change.
REQ-022 SHALL drive an_o one-hot for current index; all other bits inactive.
REQ-023 SHALL, when blank_i high, drive an_o all inactive, seg_o and dp_o off, from next cycle; scanning and loading continue.
REQ-024 SHALL apply ACTIVE_LOW inversion as the final stage on seg_o, dp_o, an_o.

Reset
REQ-025 SHALL on rst_n low: prescaler 0, index 0, shadow 0, active 0, pending 0, frame_o 0, seg_o/dp_o off, an_o all inactive (levels per ACTIVE_LOW).
REQ-026 SHALL discard pending load on reset mid-frame; first digit enabled SCAN_DIV... no: an_o[0] active on first clock after reset release.

Configuration
REQ-027 SHALL support macro SEG_SCAN_LZB_EN: defined -> leading-zero blanking; digit k>0 dark (seg_o off, an_o still asserted, dp_o honoured) when nibbles k..NUM_DIGITS-1 of active register are all 0; digit 0 never blanked.
REQ-028 SHALL, without SEG_SCAN_LZB_EN, display every digit including leading zeros.

Structure
REQ-029 SHALL place segment constants (SEG_OFF, per-hex patterns) and nibble/segment width typedefs in shared package seg_pkg.
REQ-030 SHALL implement decode in sub-module seg7_hex_decode (combinational, 4-bit in, 7-bit out), instanced once on the muxed nibble.

Verification (NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-031 SHALL cover: reset release, load 0x1234 -> after first wrap, slots 0..3 show 1011011? no: digit0=4 (1100110), digit1=3, digit2=2, digit3=1, an_o 0001,0010,0100,1000, each 4 cycles.
REQ-032 SHALL cover: load 0x5678 mid-frame -> old value finishes frame; new value from digit 0 of next frame; frame_o single pulse per 16 cycles.
REQ-033 SHALL cover: blank_i high 3 cycles -> an_o=0000, seg_o=0000000 next cycle; index still advances; resume at correct digit.
REQ-034 SHALL cover: SEG_SCAN_LZB_EN defined, load 0x0050 -> digits 3,2 dark, digit1=1101101, digit0=0111111; undefined -> digits 3,2 show 0111111.
REQ-035 SHALL cover: ACTIVE_LOW=1, load 0x000F -> digit0 seg_o=0001110, an_o=1110.
REQ-036 SHALL cover: rst_n low mid-frame with pending load -> all outputs reset values asynchronously; after release display 0000, pending discarded.
